// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues instruction RAM reads ahead of ID and buffers them with their PCs.
// Optional monitor read port enabled by defining IF_MON_RD_EN.
module if_prefetch_stage #(
   parameter int IADR_W = 10,
   parameter int QDEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_start,
   input  logic [31:2]       start_adr,
   input  logic              jmp_condition_ex,
   input  logic [31:2]       jmp_adr_ex,
   output logic              iram_ren,
   output logic [IADR_W-1:0] iram_radr,
   input  logic [31:0]       iram_rdata,
   output logic [31:0]       inst_id,
   output logic [31:2]       pc_id,
   output logic              inst_vld_id,
   input  logic              id_ready
`ifdef IF_MON_RD_EN
   ,
   input  logic              i_read_sel,
   input  logic [IADR_W-1:0] i_ram_radr,
   output logic [31:0]       i_ram_rdata
`endif
);

   localparam int CNT_W = $clog2(QDEPTH + 1);
   localparam int PTR_W = $clog2(QDEPTH);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state;
   logic [31:2]      pc_if;
   logic             vld_p1;
   logic [31:2]      pc_p1;
   logic [31:0]      mem_inst [QDEPTH];
   logic [31:2]      mem_pc   [QDEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      last_inst;
   logic [31:2]      last_pc;

   logic             mon_sel;
   logic             redirect;
   logic             credit_ok;
   logic             issue_p0;
   logic             push;
   logic             pop;

`ifdef IF_MON_RD_EN
   assign mon_sel     = i_read_sel;
   assign i_ram_rdata = iram_rdata;
   assign iram_radr   = i_read_sel ? i_ram_radr : pc_if[IADR_W+1:2];
`else
   assign mon_sel     = 1'b0;
   assign iram_radr   = pc_if[IADR_W+1:2];
`endif

   // Stage p0: issue decision. The in-flight read already owns a queue slot, so the queue can never overflow.
   always_comb begin
      redirect  = cpu_start | jmp_condition_ex;
      credit_ok = ({1'b0, count} + (CNT_W+1)'(vld_p1)) < (CNT_W+1)'(QDEPTH);
      issue_p0  = (state == RUN) && !redirect && !mon_sel && credit_ok;
      push      = vld_p1 && !redirect;
      pop       = inst_vld_id && id_ready;
   end

   assign iram_ren = issue_p0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc_if     <= '0;
         vld_p1    <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_inst <= '0;
         last_pc   <= '0;
      end else begin
         if (cpu_start) begin
            state <= RUN;
            pc_if <= start_adr;
         end else if (jmp_condition_ex) begin
            pc_if <= jmp_adr_ex;
         end else if (issue_p0) begin
            pc_if <= pc_if + 30'd1;
         end

         vld_p1 <= issue_p0;

         if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end

         if (pop) begin
            last_inst <= mem_inst[rd_ptr];
            last_pc   <= mem_pc[rd_ptr];
         end
      end
   end

   // Stage p1: read data returns and is written into the queue with the PC it was fetched from.
   always_ff @(posedge clk) begin
      if (issue_p0) pc_p1 <= pc_if;
      if (push) begin
         mem_inst[wr_ptr] <= iram_rdata;
         mem_pc[wr_ptr]   <= pc_p1;
      end
   end

   always_comb begin
      inst_vld_id = (count != '0);
      inst_id     = inst_vld_id ? mem_inst[rd_ptr] : last_inst;
      pc_id       = inst_vld_id ? mem_pc[rd_ptr]   : last_pc;
   end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: cycle table plus hand-written stall, reset and monitor sequences.
module tb_if_prefetch_stage;

   localparam int IADR_W = 10;
   localparam int QDEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cpu_start;
   logic [31:2]       start_adr;
   logic              jmp_condition_ex;
   logic [31:2]       jmp_adr_ex;
   logic              iram_ren;
   logic [IADR_W-1:0] iram_radr;
   logic [31:0]       iram_rdata;
   logic [31:0]       inst_id;
   logic [31:2]       pc_id;
   logic              inst_vld_id;
   logic              id_ready;
`ifdef IF_MON_RD_EN
   logic              i_read_sel;
   logic [IADR_W-1:0] i_ram_radr;
   logic [31:0]       i_ram_rdata;
`endif

   always #5 clk = ~clk;

   if_prefetch_stage #(.IADR_W(IADR_W), .QDEPTH(QDEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu_start        (cpu_start),
      .start_adr        (start_adr),
      .jmp_condition_ex (jmp_condition_ex),
      .jmp_adr_ex       (jmp_adr_ex),
      .iram_ren         (iram_ren),
      .iram_radr        (iram_radr),
      .iram_rdata       (iram_rdata),
      .inst_id          (inst_id),
      .pc_id            (pc_id),
      .inst_vld_id      (inst_vld_id),
      .id_ready         (id_ready)
`ifdef IF_MON_RD_EN
      ,
      .i_read_sel       (i_read_sel),
      .i_ram_radr       (i_ram_radr),
      .i_ram_rdata      (i_ram_rdata)
`endif
   );

   function automatic logic [31:0] ram_word(input logic [IADR_W-1:0] a);
      return 32'hA500_0000 | 32'(a);
   endfunction

   // RAM model: registered read of whatever address is presented
   always @(posedge clk) iram_rdata <= ram_word(iram_radr);

   typedef struct {
      logic              start;
      logic [29:0]       sadr;
      logic              jmp;
      logic [29:0]       jadr;
      logic              rdy;
      logic              e_ren;
      logic [IADR_W-1:0] e_radr;
      logic              e_vld;
      logic [29:0]       e_pc;
   } vec_t;

   vec_t tbl[23];
   int errors = 0;
   int checks = 0;

   function automatic vec_t v(input logic st, input logic [29:0] sa, input logic jp, input logic [29:0] ja,
                              input logic rd, input logic er, input logic [IADR_W-1:0] ea,
                              input logic ev, input logic [29:0] ep);
      vec_t r;
      r = '{start: st, sadr: sa, jmp: jp, jadr: ja, rdy: rd, e_ren: er, e_radr: ea, e_vld: ev, e_pc: ep};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string name, input logic [29:0] pc);
      logic [IADR_W-1:0] a;
      a = pc[IADR_W-1:0];
      check({name, " vld"}, 32'(inst_vld_id), 32'd1);
      check({name, " pc"}, 32'(pc_id), 32'(pc));
      check({name, " inst"}, inst_id, ram_word(a));
   endtask

   initial begin
      int n_ren;
      rst_n = 1'b0; cpu_start = 1'b0; start_adr = '0; jmp_condition_ex = 1'b0;
      jmp_adr_ex = '0; id_ready = 1'b0;
`ifdef IF_MON_RD_EN
      i_read_sel = 1'b0; i_ram_radr = '0;
`endif
      //            start sadr        jmp jadr   rdy ren radr    vld pc
      tbl[0]  = v(1, 30'h40,       0, 0,      1, 0, 10'h0,   0, 0);
      tbl[1]  = v(0, 0,            0, 0,      1, 1, 10'h40,  0, 0);
      tbl[2]  = v(0, 0,            0, 0,      1, 1, 10'h41,  0, 0);
      tbl[3]  = v(0, 0,            0, 0,      1, 1, 10'h42,  1, 30'h40);
      tbl[4]  = v(0, 0,            0, 0,      1, 1, 10'h43,  1, 30'h41);
      tbl[5]  = v(0, 0,            0, 0,      1, 1, 10'h44,  1, 30'h42);
      tbl[6]  = v(0, 0,            0, 0,      0, 1, 10'h45,  1, 30'h43);
      tbl[7]  = v(0, 0,            0, 0,      0, 1, 10'h46,  1, 30'h43);
      tbl[8]  = v(0, 0,            1, 30'h100, 0, 0, 10'h0,  1, 30'h43);
      tbl[9]  = v(0, 0,            0, 0,      1, 1, 10'h100, 0, 0);
      tbl[10] = v(0, 0,            0, 0,      1, 1, 10'h101, 0, 0);
      tbl[11] = v(0, 0,            0, 0,      1, 1, 10'h102, 1, 30'h100);
      tbl[12] = v(0, 0,            0, 0,      1, 1, 10'h103, 1, 30'h101);
      tbl[13] = v(1, 30'h200,      1, 30'h300, 1, 0, 10'h0,  1, 30'h102);
      tbl[14] = v(0, 0,            0, 0,      1, 1, 10'h200, 0, 0);
      tbl[15] = v(0, 0,            0, 0,      1, 1, 10'h201, 0, 0);
      tbl[16] = v(0, 0,            0, 0,      1, 1, 10'h202, 1, 30'h200);
      tbl[17] = v(1, 30'h3FFFFFFF, 0, 0,      1, 0, 10'h0,   1, 30'h201);
      tbl[18] = v(0, 0,            0, 0,      1, 1, 10'h3FF, 0, 0);
      tbl[19] = v(0, 0,            0, 0,      1, 1, 10'h000, 0, 0);
      tbl[20] = v(0, 0,            0, 0,      1, 1, 10'h001, 1, 30'h3FFFFFFF);
      tbl[21] = v(0, 0,            0, 0,      1, 1, 10'h002, 1, 30'h0);
      tbl[22] = v(0, 0,            0, 0,      1, 1, 10'h003, 1, 30'h1);

      tick();
      tick();
      check("rst ren", 32'(iram_ren), 32'd0);
      check("rst vld", 32'(inst_vld_id), 32'd0);
      check("rst inst", inst_id, 32'd0);
      check("rst pc", 32'(pc_id), 32'd0);
      check("rst radr", 32'(iram_radr), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("idle%0d ren", i), 32'(iram_ren), 32'd0);
      end

      for (int i = 0; i < 23; i++) begin
         cpu_start = tbl[i].start; start_adr = tbl[i].sadr;
         jmp_condition_ex = tbl[i].jmp; jmp_adr_ex = tbl[i].jadr;
         id_ready = tbl[i].rdy;
         #1;
         check($sformatf("vec%0d ren", i), 32'(iram_ren), 32'(tbl[i].e_ren));
         if (tbl[i].e_ren) check($sformatf("vec%0d radr", i), 32'(iram_radr), 32'(tbl[i].e_radr));
         check($sformatf("vec%0d vld", i), 32'(inst_vld_id), 32'(tbl[i].e_vld));
         if (tbl[i].e_vld) check_head($sformatf("vec%0d", i), tbl[i].e_pc);
         tick();
      end
      cpu_start = 1'b0; jmp_condition_ex = 1'b0;

      // Reset in the middle of a running stream
      #1;
      check("pre-rst ren", 32'(iram_ren), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst vld", 32'(inst_vld_id), 32'd0);
      check("midrst ren", 32'(iram_ren), 32'd0);
      check("midrst inst", inst_id, 32'd0);
      check("midrst pc", 32'(pc_id), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("postrst%0d ren", i), 32'(iram_ren), 32'd0);
         check($sformatf("postrst%0d vld", i), 32'(inst_vld_id), 32'd0);
      end

      // ID stalled: credits must stop issue at exactly QDEPTH reads
      cpu_start = 1'b1; start_adr = 30'h80; id_ready = 1'b0;
      tick();
      cpu_start = 1'b0;
      n_ren = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_ren += int'(iram_ren);
         tick();
      end
      check("stall reads", 32'(n_ren), 32'(QDEPTH));
      check("stall full ren", 32'(iram_ren), 32'd0);
      check_head("stall head", 30'h80);
      id_ready = 1'b1;
      #1;
      check("pop0 ren", 32'(iram_ren), 32'd0);
      check_head("pop0", 30'h80);
      tick();
`ifdef IF_MON_RD_EN
      id_ready = 1'b0; i_read_sel = 1'b1; i_ram_radr = 10'h5;
      #1;
      check("mon ren", 32'(iram_ren), 32'd0);
      check("mon radr", 32'(iram_radr), 32'h5);
      check_head("mon head", 30'h81);
      tick();
      i_read_sel = 1'b0; id_ready = 1'b1;
      #1;
      check("mon rdata", i_ram_rdata, ram_word(10'h5));
      check("mon resume ren", 32'(iram_ren), 32'd1);
      check("mon resume radr", 32'(iram_radr), 32'h84);
      check_head("pop1", 30'h81);
      tick();
`else
      #1;
      check("pop1 ren", 32'(iram_ren), 32'd1);
      check("pop1 radr", 32'(iram_radr), 32'h84);
      check_head("pop1", 30'h81);
      tick();
`endif
      check_head("pop2", 30'h82);
      tick();
      check_head("pop3", 30'h83);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
